// File: rtl/dit_butterfly.sv
// ---------------------------------------------------------------------------
// dit_butterfly
//
// Pipelined radix-2 decimation-in-time butterfly. The bottom input R is first
// rotated by the twiddle C with a three-multiplier (Karatsuba) complex
// product. The top input L is then added to and subtracted from the rotated
// value. L is scaled up to the product's scale so the sum and difference
// carry full precision. Each component is rounded convergently before it is
// registered on the outputs.
//
// Latency is 6 enabled clocks. Throughput is one input set per enabled clock.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      synchronous, active-high; clears the whole pipeline
//   i_clk_enable pipeline advance qualifier; all state holds when low
//   i_coef       twiddle {real, imag}, 2*CWIDTH; unity = 2^(CWIDTH-2)
//   i_left       top input L {real, imag}, 2*IWIDTH
//   i_right      bottom input R {real, imag}, 2*IWIDTH
//   i_aux        tag that travels alongside the data
//   o_left       L + R*C {real, imag}, 2*OWIDTH
//   o_right      L - R*C {real, imag}, 2*OWIDTH
//   o_aux        i_aux aligned with o_left/o_right
// ---------------------------------------------------------------------------
module dit_butterfly #(
    parameter int IWIDTH = 16,
    parameter int CWIDTH = 20,
    parameter int OWIDTH = IWIDTH + 1,
    parameter int SHIFT  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clk_enable,
    input  logic [2*CWIDTH-1:0]   i_coef,
    input  logic [2*IWIDTH-1:0]   i_left,
    input  logic [2*IWIDTH-1:0]   i_right,
    input  logic                  i_aux,
    output logic [2*OWIDTH-1:0]   o_left,
    output logic [2*OWIDTH-1:0]   o_right,
    output logic                  o_aux
);

    // Full-precision accumulator width and number of LSBs dropped on output.
    localparam int AW = IWIDTH + CWIDTH + 2;
    localparam int D  = CWIDTH - 2 + SHIFT;

    localparam logic [AW-1:0] ONE       = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] HALF      = ONE << (D - 1);
    localparam logic [AW-1:0] FRAC_MASK = (HALF << 1) - ONE;

    // Convergent (round-half-to-even) drop of D LSBs, then keep OWIDTH LSBs.
    function automatic logic signed [OWIDTH-1:0] round_conv(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] trunc;
        logic [AW-1:0]        frac;
        logic                 up;
        trunc = v >>> D;
        frac  = v & FRAC_MASK;
        up    = (frac > HALF) || ((frac == HALF) && trunc[0]);
        trunc = trunc + $signed({{(AW-1){1'b0}}, up});
        return OWIDTH'(trunc);
    endfunction

    logic signed [CWIDTH-1:0] cr_p1, ci_p1, cr_p2, ci_p2;
    logic signed [IWIDTH-1:0] rr_p1, ri_p1, rr_p2, ri_p2;
    logic signed [IWIDTH-1:0] lr_p1, li_p1, lr_p2, li_p2, lr_p3, li_p3, lr_p4, li_p4;
    logic signed [CWIDTH:0]   csum_p2;
    logic signed [IWIDTH:0]   rsum_p2;
    logic signed [AW-1:0]     prod1_p3, prod2_p3, prod3_p3;
    logic signed [AW-1:0]     mpy_r_p4, mpy_i_p4;
    logic signed [AW-1:0]     sum_r_p5, sum_i_p5, dif_r_p5, dif_i_p5;
    logic signed [OWIDTH-1:0] left_r_p6, left_i_p6, right_r_p6, right_i_p6;
    logic [5:0]               aux_sr;

    logic signed [AW-1:0]     cr_x, ci_x, rr_x, ri_x, cs_x, rs_x;
    logic signed [AW-1:0]     lr_sh, li_sh;

    always_comb begin
        cr_x  = AW'(cr_p2);
        ci_x  = AW'(ci_p2);
        rr_x  = AW'(rr_p2);
        ri_x  = AW'(ri_p2);
        cs_x  = AW'(csum_p2);
        rs_x  = AW'(rsum_p2);
        lr_sh = AW'(lr_p4) <<< (CWIDTH - 2);
        li_sh = AW'(li_p4) <<< (CWIDTH - 2);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cr_p1      <= '0;  ci_p1      <= '0;
            rr_p1      <= '0;  ri_p1      <= '0;
            lr_p1      <= '0;  li_p1      <= '0;
            cr_p2      <= '0;  ci_p2      <= '0;
            rr_p2      <= '0;  ri_p2      <= '0;
            csum_p2    <= '0;  rsum_p2    <= '0;
            lr_p2      <= '0;  li_p2      <= '0;
            prod1_p3   <= '0;  prod2_p3   <= '0;
            prod3_p3   <= '0;
            lr_p3      <= '0;  li_p3      <= '0;
            mpy_r_p4   <= '0;  mpy_i_p4   <= '0;
            lr_p4      <= '0;  li_p4      <= '0;
            sum_r_p5   <= '0;  sum_i_p5   <= '0;
            dif_r_p5   <= '0;  dif_i_p5   <= '0;
            left_r_p6  <= '0;  left_i_p6  <= '0;
            right_r_p6 <= '0;  right_i_p6 <= '0;
            aux_sr     <= '0;
        end else if (i_clk_enable) begin
            // S1: register inputs
            cr_p1 <= $signed(i_coef[2*CWIDTH-1:CWIDTH]);
            ci_p1 <= $signed(i_coef[CWIDTH-1:0]);
            rr_p1 <= $signed(i_right[2*IWIDTH-1:IWIDTH]);
            ri_p1 <= $signed(i_right[IWIDTH-1:0]);
            lr_p1 <= $signed(i_left[2*IWIDTH-1:IWIDTH]);
            li_p1 <= $signed(i_left[IWIDTH-1:0]);

            // S2: Karatsuba pre-sums, delay operands and L
            cr_p2   <= cr_p1;
            ci_p2   <= ci_p1;
            rr_p2   <= rr_p1;
            ri_p2   <= ri_p1;
            csum_p2 <= (CWIDTH+1)'(cr_p1) + (CWIDTH+1)'(ci_p1);
            rsum_p2 <= (IWIDTH+1)'(rr_p1) + (IWIDTH+1)'(ri_p1);
            lr_p2   <= lr_p1;
            li_p2   <= li_p1;

            // S3: the three real products
            prod1_p3 <= cr_x * rr_x;
            prod2_p3 <= ci_x * ri_x;
            prod3_p3 <= cs_x * rs_x;
            lr_p3    <= lr_p2;
            li_p3    <= li_p2;

            // S4: recombine into the rotated R*C
            mpy_r_p4 <= prod1_p3 - prod2_p3;
            mpy_i_p4 <= prod3_p3 - prod1_p3 - prod2_p3;
            lr_p4    <= lr_p3;
            li_p4    <= li_p3;

            // S5: full-precision sum and difference against scaled L
            sum_r_p5 <= lr_sh + mpy_r_p4;
            sum_i_p5 <= li_sh + mpy_i_p4;
            dif_r_p5 <= lr_sh - mpy_r_p4;
            dif_i_p5 <= li_sh - mpy_i_p4;

            // S6: round and register outputs
            left_r_p6  <= round_conv(sum_r_p5);
            left_i_p6  <= round_conv(sum_i_p5);
            right_r_p6 <= round_conv(dif_r_p5);
            right_i_p6 <= round_conv(dif_i_p5);

            aux_sr <= {aux_sr[4:0], i_aux};
        end
    end

    assign o_left  = {left_r_p6, left_i_p6};
    assign o_right = {right_r_p6, right_i_p6};
    assign o_aux   = aux_sr[5];

endmodule

// File: tb/tb_dit_butterfly.sv
module tb_dit_butterfly;

    localparam int IW = 16;
    localparam int CW = 20;
    localparam int OW = 17;
    localparam int U  = 262144;
    localparam int H  = 131072;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_clk_enable;
    logic [2*CW-1:0]   i_coef;
    logic [2*IW-1:0]   i_left;
    logic [2*IW-1:0]   i_right;
    logic              i_aux;
    logic [2*OW-1:0]   o_left;
    logic [2*OW-1:0]   o_right;
    logic              o_aux;

    int total = 0;
    int bad   = 0;
    int seen  = 0;

    logic signed [OW-1:0] lre, lim, rre, rim;
    assign lre = o_left[2*OW-1:OW];
    assign lim = o_left[OW-1:0];
    assign rre = o_right[2*OW-1:OW];
    assign rim = o_right[OW-1:0];

    dit_butterfly #(.IWIDTH(IW), .CWIDTH(CW), .OWIDTH(OW), .SHIFT(0)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_enable (i_clk_enable),
        .i_coef       (i_coef),
        .i_left       (i_left),
        .i_right      (i_right),
        .i_aux        (i_aux),
        .o_left       (o_left),
        .o_right      (o_right),
        .o_aux        (o_aux)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input int lr, input int li, input int rr, input int ri,
                          input int cr, input int ci, input logic aux);
        i_left  = {16'(lr), 16'(li)};
        i_right = {16'(rr), 16'(ri)};
        i_coef  = {20'(cr), 20'(ci)};
        i_aux   = aux;
    endtask

    task automatic clear_in();
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int elr, input int eli,
                             input int err, input int eri, input int eaux);
        chk({tag, ".left_re"},  32'(lre), elr);
        chk({tag, ".left_im"},  32'(lim), eli);
        chk({tag, ".right_re"}, 32'(rre), err);
        chk({tag, ".right_im"}, 32'(rim), eri);
        chk({tag, ".aux"},      {31'b0, o_aux}, eaux);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_clk_enable = 1'b1;
        clear_in();
        tick();
        tick();
        check_out("reset", 0, 0, 0, 0, 0);
        i_reset = 1'b0;

        // Basic unity twiddle, exact latency, single aux pulse
        set_in(100, 0, 50, 0, U, 0, 1'b1);
        tick();
        clear_in();
        repeat (4) tick();
        chk("basic.early_aux", {31'b0, o_aux}, 0);
        tick();
        check_out("basic", 150, 0, 50, 0, 1);
        tick();
        chk("basic.aux_once", {31'b0, o_aux}, 0);

        // Rotation by -j
        set_in(10, 10, 0, 40, 0, -U, 1'b1);
        tick();
        clear_in();
        repeat (5) tick();
        check_out("rot_mj", 50, 10, -30, 10, 1);

        // Convergent rounding, back-to-back sets and aux pulses
        set_in(0, 0, 1, 0, H, 0, 1'b1);
        tick();
        set_in(0, 0, 3, 0, H, 0, 1'b1);
        tick();
        set_in(0, 0, 5, 0, H, 0, 1'b1);
        tick();
        clear_in();
        repeat (3) tick();
        check_out("round_r1", 0, 0, 0, 0, 1);
        tick();
        check_out("round_r3", 2, 0, -2, 0, 1);
        tick();
        check_out("round_r5", 2, 0, -2, 0, 1);
        tick();
        chk("round.aux_end", {31'b0, o_aux}, 0);

        // Stall for 3 cycles between enabled clocks 2 and 3
        set_in(100, 0, 50, 0, U, 0, 1'b1);
        tick();
        clear_in();
        tick();
        i_clk_enable = 1'b0;
        set_in(7, 7, 7, 7, U, 0, 1'b1);
        repeat (3) tick();
        chk("stall.hold_aux", {31'b0, o_aux}, 0);
        clear_in();
        i_clk_enable = 1'b1;
        repeat (3) tick();
        chk("stall.early_aux", {31'b0, o_aux}, 0);
        tick();
        check_out("stall", 150, 0, 50, 0, 1);
        tick();
        chk("stall.aux_once", {31'b0, o_aux}, 0);

        // Reset clears nonzero outputs even with enable low
        set_in(100, 0, 0, 0, U, 0, 1'b0);
        repeat (6) tick();
        chk("fill.left_re",  32'(lre), 100);
        chk("fill.right_re", 32'(rre), 100);
        clear_in();
        i_clk_enable = 1'b0;
        i_reset      = 1'b1;
        tick();
        i_reset      = 1'b0;
        i_clk_enable = 1'b1;
        check_out("rst_noen", 0, 0, 0, 0, 0);

        // Reset mid-flight discards data and aux
        set_in(100, 0, 50, 0, U, 0, 1'b1);
        tick();
        clear_in();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o_aux === 1'b1 || lre !== 0) seen++;
        end
        chk("flush.activity", seen, 0);
        check_out("flush", 0, 0, 0, 0, 0);
        set_in(10, 10, 0, 40, 0, -U, 1'b1);
        tick();
        clear_in();
        repeat (4) tick();
        chk("post_rst.early_aux", {31'b0, o_aux}, 0);
        tick();
        check_out("post_rst", 50, 10, -30, 10, 1);

        // Extreme magnitudes, no wrap
        set_in(32767, -32768, 32767, -32768, U, 0, 1'b1);
        tick();
        clear_in();
        repeat (5) tick();
        check_out("maxmag", 65534, -65536, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
